axi4_stream_marker_framer: RTL and testbench

Parametrised AXI4-Stream framer that inserts a header (the `marker` word, split into DATA_W-wide beats) ahead of every payload segment. Input frames are cut into segments of at most LEN beats; each segment is emitted as header beats followed by its payload, with `m_tlast` closing the segment. It sits between a raw stream source and downstream segment-based consumers, and replaces the fixed 8-bit/4-beat framer with a generalised width/length/marker version with full backpressure and header tagging.

---
 rtl/axi4_stream_marker_framer.sv | 138 +++++++++++++
 tb/tb_axi4_stream_marker_framer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_stream_marker_framer.sv
// AXI4-Stream framer: cuts input frames into segments of at most LEN beats and
// prefixes each segment with the marker word, emitted MSB-first as DATA_W beats.
module axi4_stream_marker_framer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned LEN      = 4,
    parameter int unsigned MARKER_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic                s_tvalid,
    input  logic                s_tlast,
    output logic                s_tready,
    input  logic [MARKER_W-1:0] marker,
    output logic [DATA_W-1:0]   m_tdata,
    output logic                m_tvalid,
    output logic                m_tlast,
    output logic                m_tuser,
    input  logic                m_tready
);

    localparam int unsigned HB  = MARKER_W / DATA_W;
    localparam int unsigned HCW = (HB > 1) ? $clog2(HB) : 1;
    localparam int unsigned PCW = $clog2(LEN) + 1;

    typedef enum logic [1:0] {StIdle, StHdr, StPayload} state_e;

    state_e                state_q, state_d;
    logic [HCW-1:0]        hcnt_q, hcnt_d;
    logic [PCW-1:0]        pcnt_q, pcnt_d;
    logic [MARKER_W-1:0]   mreg_q, mreg_d;
    logic [DATA_W-1:0]     m_tdata_q, m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;
    logic                  m_tuser_q, m_tuser_d;

    logic                  slot_free;
    logic                  hdr_last;
    logic                  seg_full;
    int unsigned           hdr_msb;

    assign slot_free = !m_tvalid_q || m_tready;
    assign s_tready  = (state_q == StPayload) && slot_free;
    assign hdr_last  = (hcnt_q == HCW'(HB - 1));
    assign seg_full  = (pcnt_q == PCW'(LEN - 1));
    assign hdr_msb   = MARKER_W - 1 - 32'(hcnt_q) * DATA_W;

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign m_tuser  = m_tuser_q;

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        pcnt_d     = pcnt_q;
        mreg_d     = mreg_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tuser_d  = m_tuser_q;

        // A completed transfer empties the slot unless a new beat is loaded below.
        if (slot_free) begin
            m_tvalid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (s_tvalid) begin
                    mreg_d  = marker;
                    hcnt_d  = '0;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (slot_free) begin
                    m_tdata_d  = mreg_q[hdr_msb -: DATA_W];
                    m_tuser_d  = 1'b1;
                    m_tlast_d  = 1'b0;
                    m_tvalid_d = 1'b1;
                    if (hdr_last) begin
                        hcnt_d  = '0;
                        pcnt_d  = '0;
                        state_d = StPayload;
                    end else begin
                        hcnt_d = hcnt_q + HCW'(1);
                    end
                end
            end
            StPayload: begin
                if (s_tvalid && slot_free) begin
                    m_tdata_d  = s_tdata;
                    m_tuser_d  = 1'b0;
                    m_tlast_d  = s_tlast || seg_full;
                    m_tvalid_d = 1'b1;
                    pcnt_d     = pcnt_q + PCW'(1);
                    if (s_tlast) begin
                        pcnt_d  = '0;
                        state_d = StIdle;
                    end else if (seg_full) begin
                        // Continuation segment picks up whatever marker is present now.
                        pcnt_d  = '0;
                        mreg_d  = marker;
                        hcnt_d  = '0;
                        state_d = StHdr;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            hcnt_q     <= '0;
            pcnt_q     <= '0;
            mreg_q     <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            pcnt_q     <= pcnt_d;
            mreg_q     <= mreg_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tuser_q  <= m_tuser_d;
        end
    end

endmodule

// File: tb/tb_axi4_stream_marker_framer.sv
// Bench for axi4_stream_marker_framer: directed and randomized frames checked against a
// segment-level reference model, plus a 16-bit/LEN=2 instance with a fixed expected stream.
module tb_axi4_stream_marker_framer;

    localparam int unsigned LEN = 4;
    localparam int unsigned HB  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] marker;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tuser;
    wire         m_tready;

    logic [15:0] s2_tdata;
    logic        s2_tvalid;
    logic        s2_tlast;
    logic        s2_tready;
    logic [31:0] marker2;
    logic [15:0] m2_tdata;
    logic        m2_tvalid;
    logic        m2_tlast;
    logic        m2_tuser;
    logic        m2_tready;

    logic        rdy_mode;
    logic        rdy_force;
    logic        rdy_rand = 1'b1;

    logic [9:0]  obs_q[$];
    logic [9:0]  exp_q[$];
    logic [17:0] obs2_q[$];
    int          obs_rd = 0;
    int          exp_rd = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    assign m_tready = rdy_mode ? rdy_rand : rdy_force;

    axi4_stream_marker_framer #(.DATA_W(8), .LEN(4), .MARKER_W(32)) u_dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .marker(marker),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .m_tready(m_tready)
    );

    axi4_stream_marker_framer #(.DATA_W(16), .LEN(2), .MARKER_W(32)) u_dut2 (
        .clk(clk), .reset(reset),
        .s_tdata(s2_tdata), .s_tvalid(s2_tvalid), .s_tlast(s2_tlast), .s_tready(s2_tready),
        .marker(marker2),
        .m_tdata(m2_tdata), .m_tvalid(m2_tvalid), .m_tlast(m2_tlast), .m_tuser(m2_tuser),
        .m_tready(m2_tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    // Inputs only change just after posedge, so a negedge handshake is the next-edge transfer.
    always @(negedge clk) begin
        if (reset && m_tvalid && m_tready) obs_q.push_back({m_tuser, m_tlast, m_tdata});
        if (reset && m2_tvalid && m2_tready) obs2_q.push_back({m2_tuser, m2_tlast, m2_tdata});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " m_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, " m_tdata"}, 32'(m_tdata), 32'd0);
        chk({tag, " m_tlast"}, 32'(m_tlast), 32'd0);
        chk({tag, " m_tuser"}, 32'(m_tuser), 32'd0);
        chk({tag, " s_tready"}, 32'(s_tready), 32'd0);
    endtask

    // Reference: each run of up to LEN payload beats is preceded by the marker bytes MSB-first;
    // the first segment uses mk, continuation segments use mk2.
    task automatic send_frame(input int n, input logic [31:0] mk, input logic [31:0] mk2,
                              input bit gaps);
        logic [7:0]  pay[$];
        logic [31:0] m;
        int          seg;
        int          k;
        logic        acc;
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
        seg = 0;
        for (int i = 0; i < n; i += LEN) begin
            m = (seg == 0) ? mk : mk2;
            for (int h = 0; h < HB; h++) exp_q.push_back({1'b1, 1'b0, m[31 - 8*h -: 8]});
            for (int j = i; j < n && j < i + LEN; j++)
                exp_q.push_back({1'b0, (j == n - 1) || (j == i + LEN - 1), pay[j]});
            seg++;
        end
        marker = mk;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = pay[i];
            s_tlast  = (i == n - 1);
            acc = 1'b0;
            k = 0;
            while (!acc && k < 500) begin
                @(negedge clk);
                acc = s_tready;
                @(posedge clk); #1;
                k++;
            end
            chk("source beat accepted", 32'(acc), 32'd1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((obs_q.size() - obs_rd) < (exp_q.size() - exp_rd) && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic compare_all(input string tag);
        int n_obs = obs_q.size() - obs_rd;
        int n_exp = exp_q.size() - exp_rd;
        chk({tag, " beat count"}, 32'(n_obs), 32'(n_exp));
        for (int i = 0; i < n_obs && i < n_exp; i++)
            chk({tag, " beat {user,last,data}"}, 32'(obs_q[obs_rd + i]), 32'(exp_q[exp_rd + i]));
        obs_rd = obs_q.size();
        exp_rd = exp_q.size();
    endtask

    initial begin
        logic [9:0]  pend;
        logic [15:0] p2[3];
        logic [17:0] exp2[7];
        logic        acc;
        int          k;
        int          nacc;

        reset = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; marker = '0;
        s2_tdata = '0; s2_tvalid = 1'b0; s2_tlast = 1'b0; marker2 = '0; m2_tready = 1'b1;
        rdy_mode = 1'b0;
        rdy_force = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // 14-beat frame, always ready: 4 segments, 30 output beats.
        send_frame(14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        drain();
        compare_all("frame14");

        // Same frame with a 3-cycle downstream stall in the first payload run.
        fork
            send_frame(14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
            begin
                repeat (8) @(posedge clk);
                #1;
                rdy_force = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    pend = exp_q[exp_rd + (obs_q.size() - obs_rd)];
                    chk("stall s_tready", 32'(s_tready), 32'd0);
                    chk("stall m_tvalid", 32'(m_tvalid), 32'd1);
                    chk("stall held beat", 32'({m_tuser, m_tlast, m_tdata}), 32'(pend));
                end
                @(posedge clk); #1;
                rdy_force = 1'b1;
            end
        join
        drain();
        compare_all("stall");

        // Exactly LEN beats: one segment, then the framer must stay quiet.
        send_frame(4, 32'h5A5A_0FF0, 32'h5A5A_0FF0, 1'b0);
        drain();
        repeat (6) @(posedge clk);
        #1;
        chk("len4 idle m_tvalid", 32'(m_tvalid), 32'd0);
        compare_all("len4");

        // Marker changes during the header: only the continuation segment sees it.
        fork
            send_frame(5, 32'h1234_5678, 32'hAABB_CCDD, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1;
                marker = 32'hAABB_CCDD;
            end
        join
        drain();
        compare_all("marker latch");

        // Reset after two payload beats; partial segment is discarded.
        marker = 32'hFFFF_FFFF;
        s_tvalid = 1'b1;
        s_tlast = 1'b0;
        nacc = 0;
        k = 0;
        while (nacc < 2 && k < 50) begin
            s_tdata = 8'($urandom);
            @(negedge clk);
            if (s_tready) nacc++;
            @(posedge clk); #1;
            k++;
        end
        chk("pre-reset payload beats", 32'(nacc), 32'd2);
        s_tvalid = 1'b0;
        reset = 1'b0;
        #1;
        chk_reset_outputs("mid-reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        obs_rd = obs_q.size();
        send_frame(3, 32'h0A0B_0C0D, 32'h0A0B_0C0D, 1'b0);
        drain();
        compare_all("after reset");

        // Randomized frames with random source gaps and random backpressure.
        rdy_mode = 1'b1;
        for (int f = 0; f < 25; f++) begin
            logic [31:0] mk;
            mk = $urandom;
            send_frame(int'($urandom_range(1, 10)), mk, mk, 1'b1);
        end
        drain();
        rdy_mode = 1'b0;
        compare_all("random");

        // 16-bit beats, LEN=2: DEAD BEEF p1 p2(last) DEAD BEEF p3(last).
        p2   = '{16'h1111, 16'h2222, 16'h3333};
        exp2 = '{{2'b10, 16'hDEAD}, {2'b10, 16'hBEEF}, {2'b00, 16'h1111}, {2'b01, 16'h2222},
                 {2'b10, 16'hDEAD}, {2'b10, 16'hBEEF}, {2'b01, 16'h3333}};
        marker2 = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            s2_tvalid = 1'b1;
            s2_tdata  = p2[i];
            s2_tlast  = (i == 2);
            acc = 1'b0;
            k = 0;
            while (!acc && k < 100) begin
                @(negedge clk);
                acc = s2_tready;
                @(posedge clk); #1;
                k++;
            end
            chk("w16 source beat accepted", 32'(acc), 32'd1);
        end
        s2_tvalid = 1'b0;
        s2_tlast  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("w16 beat count", 32'(obs2_q.size()), 32'd7);
        for (int i = 0; i < 7 && i < obs2_q.size(); i++)
            chk("w16 beat {user,last,data}", 32'(obs2_q[i]), 32'(exp2[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
